// File: rtl/line_buffer_fetch_if.sv
// SDRAM arbiter handshake for the display line buffer client.
// master = line buffer fetch side, slave = arbiter side.
interface line_buffer_fetch_if;
    logic         lb_sdram_Wait;
    logic         lb_sdram_ac;
    logic [127:0] lb_sdram_data;
    logic         lb_sdram_rd;
    logic [21:0]  lb_sdram_addr;
    logic         lb_Busy;
    logic         lb_done;

    modport master (
        input  lb_sdram_Wait, lb_sdram_ac, lb_sdram_data,
        output lb_sdram_rd, lb_sdram_addr, lb_Busy, lb_done
    );

    modport slave (
        output lb_sdram_Wait, lb_sdram_ac, lb_sdram_data,
        input  lb_sdram_rd, lb_sdram_addr, lb_Busy, lb_done
    );
endinterface

// File: rtl/line_buffer_fetch.sv
// Prefetches the next scanline from the framebuffer into a ping-pong line
// buffer and streams the displayed line to the VGA pixel path.
module line_buffer_fetch #(
    parameter logic [21:0] FB_BASE        = 22'h000000,
    parameter int          WORDS_PER_LINE = 80,
    parameter int          H_VISIBLE      = 640,
    parameter int          V_VISIBLE      = 480,
    parameter int          V_LAST         = 524,
    parameter int          FETCH_X        = 799
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                new_frame,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    line_buffer_fetch_if.master lb,
    output logic [15:0]         pixel_out,
    output logic                underrun
);
    localparam int WW = $clog2(WORDS_PER_LINE);
    localparam int AW = $clog2(2 * WORDS_PER_LINE);

    localparam logic [9:0]    FETCH_X_C  = 10'(FETCH_X);
    localparam logic [9:0]    H_VIS_C    = 10'(H_VISIBLE);
    localparam logic [9:0]    V_VIS_C    = 10'(V_VISIBLE);
    localparam logic [9:0]    V_LAST_C   = 10'(V_LAST);
    localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS_PER_LINE - 1);
    localparam logic [AW-1:0] BANK1_BASE = AW'(WORDS_PER_LINE);
    localparam logic [21:0]   WPL_C      = 22'(WORDS_PER_LINE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] word_q, word_d;
    logic [9:0]    tgt_q, tgt_d;
    logic          disp_q, disp_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;

    logic          at_fetch_x, swap, abandon, trigger, ack;
    logic [9:0]    tgt_next;
    logic [AW-1:0] fill_addr, rd_addr;
    logic [WW-1:0] rd_col;
    logic          pix_vis;

    logic [127:0]  line_ram [2*WORDS_PER_LINE];
    logic [127:0]  pix_word_q;
    logic [2:0]    pix_sel_q;
    logic          pix_vis_q;

    always_comb begin
        at_fetch_x = (DrawX == FETCH_X_C);
        tgt_next   = (DrawY == V_LAST_C) ? '0 : DrawY + 10'd1;
        // Swap sees the old line-ready; an abandoned fetch frees the FSM for this cycle's trigger.
        swap       = at_fetch_x && ready_q;
        abandon    = at_fetch_x && !ready_q && (state_q == ST_REQ);
        trigger    = at_fetch_x && ((state_q == ST_IDLE) || abandon) && (tgt_next < V_VIS_C);
        ack        = (state_q == ST_REQ) && lb.lb_sdram_ac && !lb.lb_sdram_Wait && !abandon;

        state_d    = state_q;
        word_d     = word_q;
        tgt_d      = tgt_q;
        disp_d     = disp_q;
        ready_d    = ready_q;
        done_d     = done_q;
        underrun_d = underrun_q;

        if (new_frame) begin
            done_d = 1'b0;
        end

        case (state_q)
            ST_REQ: begin
                if (ack) begin
                    if (word_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                if (tgt_q == V_VIS_C - 10'd1) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (swap) begin
            disp_d  = ~disp_q;
            ready_d = 1'b0;
        end
        if (abandon) begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
        end
        if (trigger) begin
            state_d = ST_REQ;
            tgt_d   = tgt_next;
            word_d  = '0;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            tgt_q      <= '0;
            disp_q     <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            tgt_q      <= tgt_d;
            disp_q     <= disp_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign lb.lb_sdram_rd   = (state_q == ST_REQ);
    assign lb.lb_sdram_addr = (state_q == ST_REQ) ? FB_BASE + 22'(tgt_q) * WPL_C + 22'(word_q) : '0;
    assign lb.lb_Busy       = (state_q == ST_REQ);
    assign lb.lb_done       = done_q;
    assign underrun         = underrun_q;

    // Fill bank is always the one not being displayed.
    always_comb begin
        fill_addr = disp_q ? AW'(word_q) : BANK1_BASE + AW'(word_q);
        pix_vis   = (DrawX < H_VIS_C) && (DrawY < V_VIS_C);
        rd_col    = pix_vis ? WW'(DrawX[9:3]) : '0;
        rd_addr   = disp_q ? BANK1_BASE + AW'(rd_col) : AW'(rd_col);
    end

    always_ff @(posedge clk) begin
        if (ack) begin
            line_ram[fill_addr] <= lb.lb_sdram_data;
        end
        pix_word_q <= line_ram[rd_addr];
        pix_sel_q  <= DrawX[2:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_vis_q <= 1'b0;
        end else begin
            pix_vis_q <= pix_vis;
        end
    end

    assign pixel_out = pix_vis_q ? pix_word_q[{pix_sel_q, 4'b0000} +: 16] : '0;
endmodule

// File: tb/tb_line_buffer_fetch.sv
// Randomized self-checking bench for line_buffer_fetch against a
// transaction-level model of line fetches, bank swaps and the pixel path.
module tb_line_buffer_fetch;
    localparam int          WPL = 80;
    localparam logic [21:0] FB  = 22'h000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_frame = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [15:0] pixel_out;
    logic        underrun;

    line_buffer_fetch_if lbif();

    line_buffer_fetch #(
        .FB_BASE        (FB),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .new_frame (new_frame),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .lb        (lbif.master),
        .pixel_out (pixel_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: bank contents as written by acked words, plus line-level flags.
    logic [127:0] exp_bank [2][WPL];
    int m_disp, m_T, m_word;
    bit m_ready, m_fetching, m_underrun, m_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] ramp_word(input int k);
        logic [127:0] w;
        for (int i = 0; i < 8; i++) w[i*16 +: 16] = 16'(k * 8 + i);
        return w;
    endfunction

    function automatic logic [15:0] pix_model(input int x, input int y);
        logic [127:0] w;
        if (x < 640 && y < 480) begin
            w = exp_bank[m_disp][x / 8];
            return w[(x % 8) * 16 +: 16];
        end
        return '0;
    endfunction

    // Line-level effect of DrawX reaching 799 on line y.
    task automatic model_edge799(input int y);
        int t;
        t = (y == 524) ? 0 : y + 1;
        if (m_ready) begin
            m_disp  = 1 - m_disp;
            m_ready = 1'b0;
        end else if (m_fetching) begin
            m_underrun = 1'b1;
            m_fetching = 1'b0;
        end
        if (!m_fetching && t < 480) begin
            m_fetching = 1'b1;
            m_T        = t;
            m_word     = 0;
            m_ready    = 1'b0;
        end
    endtask

    task automatic start_fetch(input int y);
        DrawY = 10'(y);
        DrawX = 10'd799;
        model_edge799(y);
        tick;
        DrawX = 10'd100;
        chk("trig_rd", 32'(lbif.lb_sdram_rd), 32'(m_fetching));
    endtask

    task automatic swap_only;
        DrawY = 10'd479;
        DrawX = 10'd799;
        model_edge799(479);
        tick;
        DrawX = 10'd100;
    endtask

    // mode 0: ac held high; mode 1: Wait 20 cycles then ac every 3rd; mode 2: random.
    task automatic serve(input int mode, input bit ramp, input int stop);
        int cyc;
        bit w, a;
        logic [127:0] d;
        cyc = 0;
        while (m_word < stop) begin
            if (cyc > 3000) begin
                chk("serve_timeout", 32'(m_word), 32'(stop));
                break;
            end
            chk("rd_hold", 32'(lbif.lb_sdram_rd), 32'd1);
            chk("busy", 32'(lbif.lb_Busy), 32'd1);
            chk("addr", 32'(lbif.lb_sdram_addr), 32'(FB) + 32'(m_T * WPL + m_word));
            case (mode)
                0: begin w = 1'b0; a = 1'b1; end
                1: begin w = (cyc < 20); a = !w && (cyc % 3 == 2); end
                default: begin
                    w = ($urandom_range(0, 3) == 0);
                    a = !w && ($urandom_range(0, 1) == 1);
                end
            endcase
            d = ramp ? ramp_word(m_word) : rand_word();
            lbif.lb_sdram_Wait = w;
            lbif.lb_sdram_ac   = a;
            lbif.lb_sdram_data = d;
            if (a) begin
                exp_bank[1 - m_disp][m_word] = d;
                m_word++;
            end
            cyc++;
            tick;
        end
        lbif.lb_sdram_Wait = 1'b0;
        lbif.lb_sdram_data = rand_word();
        if (m_word == WPL) begin
            // A held ack during the completion cycle must not write anything.
            lbif.lb_sdram_ac = (mode == 0);
            chk("rd_end", 32'(lbif.lb_sdram_rd), 32'd0);
            chk("busy_end", 32'(lbif.lb_Busy), 32'd0);
            tick;
            lbif.lb_sdram_ac = 1'b0;
            m_fetching = 1'b0;
            m_ready    = 1'b1;
            if (m_T == 479) m_done = 1'b1;
            chk("done", 32'(lbif.lb_done), 32'(m_done));
            chk("underrun", 32'(underrun), 32'(m_underrun));
        end else begin
            lbif.lb_sdram_ac = 1'b0;
        end
    endtask

    task automatic sweep(input int yy, input int x0, input int x1);
        logic [15:0] e;
        for (int x = x0; x <= x1; x++) begin
            DrawX = 10'(x);
            DrawY = 10'(yy);
            e = pix_model(x, yy);
            if (x == 799) model_edge799(yy);
            tick;
            chk("pixel", 32'(pixel_out), 32'(e));
        end
        DrawX = 10'd100;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int y;
        lbif.lb_sdram_Wait = 1'b0;
        lbif.lb_sdram_ac   = 1'b0;
        lbif.lb_sdram_data = '0;
        m_disp = 0; m_T = 0; m_word = 0;
        m_ready = 1'b0; m_fetching = 1'b0; m_underrun = 1'b0; m_done = 1'b0;

        reset = 1'b1;
        tick;
        tick;
        chk("rst_rd", 32'(lbif.lb_sdram_rd), 32'd0);
        chk("rst_addr", 32'(lbif.lb_sdram_addr), 32'd0);
        chk("rst_busy", 32'(lbif.lb_Busy), 32'd0);
        chk("rst_done", 32'(lbif.lb_done), 32'd0);
        chk("rst_pixel", 32'(pixel_out), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        tick;

        // Line 0 prefetched during the last line of the frame.
        start_fetch(524);
        serve(0, 1'b0, WPL);
        swap_only;
        sweep(479, 0, 799);

        // Stalled grant then sparse acks; ramp data makes pixel == DrawX.
        start_fetch(10);
        serve(1, 1'b1, WPL);
        swap_only;
        sweep(479, 0, 799);
        sweep(500, 0, 15);

        repeat (3) begin
            y = $urandom_range(0, 477);
            start_fetch(y);
            serve(2, 1'b0, WPL);
            swap_only;
            sweep(479, 0, 799);
            sweep($urandom_range(0, 478), 0, 63);
        end

        // Final line of the frame sets lb_done; T=480 must not trigger.
        start_fetch(478);
        serve(2, 1'b0, WPL);
        swap_only;
        chk("no_trig_rd", 32'(lbif.lb_sdram_rd), 32'd0);
        chk("no_trig_busy", 32'(lbif.lb_Busy), 32'd0);
        sweep(479, 0, 63);
        new_frame = 1'b1;
        tick;
        new_frame = 1'b0;
        m_done = 1'b0;
        chk("done_clr", 32'(lbif.lb_done), 32'd0);

        // Starved fetch: swap point reached with the line incomplete.
        start_fetch($urandom_range(0, 200));
        for (int i = 0; i < 100; i++) begin
            chk("stall_rd", 32'(lbif.lb_sdram_rd), 32'd1);
            chk("stall_addr", 32'(lbif.lb_sdram_addr), 32'(FB) + 32'(m_T * WPL));
            tick;
        end
        start_fetch($urandom_range(201, 477));
        chk("underrun_set", 32'(underrun), 32'd1);
        serve(2, 1'b0, WPL);
        swap_only;
        sweep(479, 0, 799);

        // Reset in the middle of a line.
        y = $urandom_range(0, 477);
        start_fetch(y);
        serve(2, 1'b0, 40);
        reset = 1'b1;
        tick;
        m_disp = 0; m_ready = 1'b0; m_fetching = 1'b0; m_underrun = 1'b0; m_done = 1'b0;
        chk("mid_rst_rd", 32'(lbif.lb_sdram_rd), 32'd0);
        chk("mid_rst_busy", 32'(lbif.lb_Busy), 32'd0);
        chk("mid_rst_addr", 32'(lbif.lb_sdram_addr), 32'd0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        sweep(479, 0, 799);
        start_fetch(y);
        serve(0, 1'b0, WPL);
        swap_only;
        sweep(479, 0, 799);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
